// File: rtl/rotary_decoder_if.sv
// Encoder-side bundle for the rotary decoder: raw quadrature channels in,
// detent step/direction/position/error out.
interface rotary_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic       step;
  logic       dir;
  logic [7:0] pos;
  logic       err;

  modport master (output enc_a, enc_b, input step, dir, pos, err);
  modport slave  (input enc_a, enc_b, output step, dir, pos, err);
endinterface

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder: synchronizes and debounces both channels,
// tracks sub-detent progress and emits one step pulse per full detent.
module rotary_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  rotary_decoder_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0]  DETENT = 2'b11;

  // Channel pairs are ordered {A, B}.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] deb;

  logic [1:0]        prev_q;
  logic [1:0]        prev_d;
  logic signed [3:0] acc_q;
  logic signed [3:0] acc_d;
  logic signed [3:0] acc_inc;
  logic              step_q;
  logic              step_d;
  logic              err_q;
  logic              err_d;
  logic              dir_q;
  logic              dir_d;
  logic [7:0]        pos_q;
  logic [7:0]        pos_d;
  logic              cw_c;

  // Two-flop synchronizer; idles high to match the detent state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {bus.enc_a, bus.enc_b};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: accept a new level only after it persists.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        deb_q <= 1'b1;
        cnt_q <= '0;
      end else if (sync2_q[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign deb[i] = deb_q;
  end

  // A single-bit change is clockwise when it follows 11->10->00->01->11.
  always_comb begin
    cw_c = 1'b0;
    case ({prev_q, deb})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: cw_c = 1'b1;
      default:                                cw_c = 1'b0;
    endcase
  end

  // Decoder next-state: accumulate legal transitions, resolve on entry to detent.
  always_comb begin
    prev_d  = deb;
    acc_d   = acc_q;
    acc_inc = acc_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    if (deb != prev_q) begin
      if ((deb[1] != prev_q[1]) && (deb[0] != prev_q[0])) begin
        err_d = 1'b1;
        acc_d = '0;
      end else begin
        if (cw_c) begin
          acc_inc = (acc_q == 4'sd4) ? acc_q : acc_q + 4'sd1;
        end else begin
          acc_inc = (acc_q == -4'sd4) ? acc_q : acc_q - 4'sd1;
        end
        acc_d = acc_inc;
        if (deb == DETENT) begin
          acc_d = '0;
          if (acc_inc == 4'sd4) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + 8'd1;
          end else if (acc_inc == -4'sd4) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= DETENT;
      acc_q  <= '0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
      pos_q  <= 8'h00;
    end else begin
      prev_q <= prev_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      err_q  <= err_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
    end
  end

  assign bus.step = step_q;
  assign bus.err  = err_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES = 4.
module tb_rotary_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   step_cnt;
  int   err_cnt;
  int   both_cnt;

  rotary_decoder_if bus ();

  rotary_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.step === 1'b1) step_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.step === 1'b1 && bus.err === 1'b1) both_cnt++;
  end

  task automatic phase(input logic a, input logic b, input int n);
    bus.enc_a = a;
    bus.enc_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic cw_detent(input int n);
    phase(1'b1, 1'b0, n);
    phase(1'b0, 1'b0, n);
    phase(1'b0, 1'b1, n);
    phase(1'b1, 1'b1, n);
  endtask

  task automatic ccw_detent(input int n);
    phase(1'b0, 1'b1, n);
    phase(1'b0, 1'b0, n);
    phase(1'b1, 1'b0, n);
    phase(1'b1, 1'b1, n);
  endtask

  task automatic glitch_phase(input logic a, input logic b);
    phase(a, b, 6);
    phase(~a, b, 2);
    phase(a, b, 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int s0;
    int e0;
    rst = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", bus.step); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.pos !== 8'h00) begin failures++; $display("FAIL reset_pos got=%h exp=00", bus.pos); end
    checks++; if (bus.dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", bus.dir); end
    rst = 1'b0;
    s0 = step_cnt;
    e0 = err_cnt;
    phase(1'b1, 1'b1, 20);
    checks++; if (step_cnt - s0 !== 0) begin failures++; $display("FAIL release_steps got=%0d exp=0", step_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL release_errs got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_cw();
    int s0;
    int e0;
    s0 = step_cnt;
    e0 = err_cnt;
    cw_detent(10);
    checks++; if (step_cnt - s0 !== 1) begin failures++; $display("FAIL cw_steps got=%0d exp=1", step_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL cw_errs got=%0d exp=0", err_cnt - e0); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL cw_dir got=%b exp=1", bus.dir); end
    checks++; if (bus.pos !== 8'h01) begin failures++; $display("FAIL cw_pos got=%h exp=01", bus.pos); end
  endtask

  task automatic test_ccw();
    int s0;
    int e0;
    do_reset();
    s0 = step_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) ccw_detent(10);
    checks++; if (step_cnt - s0 !== 3) begin failures++; $display("FAIL ccw_steps got=%0d exp=3", step_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL ccw_errs got=%0d exp=0", err_cnt - e0); end
    checks++; if (bus.dir !== 1'b0) begin failures++; $display("FAIL ccw_dir got=%b exp=0", bus.dir); end
    checks++; if (bus.pos !== 8'hFD) begin failures++; $display("FAIL ccw_pos got=%h exp=fd", bus.pos); end
  endtask

  task automatic test_glitch();
    int s0;
    int e0;
    do_reset();
    s0 = step_cnt;
    e0 = err_cnt;
    glitch_phase(1'b1, 1'b0);
    glitch_phase(1'b0, 1'b0);
    glitch_phase(1'b0, 1'b1);
    glitch_phase(1'b1, 1'b1);
    checks++; if (step_cnt - s0 !== 1) begin failures++; $display("FAIL glitch_steps got=%0d exp=1", step_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_errs got=%0d exp=0", err_cnt - e0); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL glitch_dir got=%b exp=1", bus.dir); end
    checks++; if (bus.pos !== 8'h01) begin failures++; $display("FAIL glitch_pos got=%h exp=01", bus.pos); end
  endtask

  task automatic test_illegal();
    int s0;
    int e0;
    s0 = step_cnt;
    e0 = err_cnt;
    phase(1'b0, 1'b0, 10);
    phase(1'b1, 1'b1, 10);
    checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL illegal_errs got=%0d exp=2", err_cnt - e0); end
    checks++; if (step_cnt - s0 !== 0) begin failures++; $display("FAIL illegal_steps got=%0d exp=0", step_cnt - s0); end
    checks++; if (bus.pos !== 8'h01) begin failures++; $display("FAIL illegal_pos got=%h exp=01", bus.pos); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL illegal_dir got=%b exp=1", bus.dir); end
  endtask

  task automatic test_reversal();
    int s0;
    int e0;
    ccw_detent(10);
    s0 = step_cnt;
    e0 = err_cnt;
    phase(1'b1, 1'b0, 10);
    phase(1'b0, 1'b0, 10);
    phase(1'b1, 1'b0, 10);
    phase(1'b1, 1'b1, 10);
    checks++; if (step_cnt - s0 !== 0) begin failures++; $display("FAIL rev_steps got=%0d exp=0", step_cnt - s0); end
    checks++; if (bus.pos !== 8'h00) begin failures++; $display("FAIL rev_pos got=%h exp=00", bus.pos); end
    checks++; if (bus.dir !== 1'b0) begin failures++; $display("FAIL rev_dir got=%b exp=0", bus.dir); end
    cw_detent(10);
    checks++; if (step_cnt - s0 !== 1) begin failures++; $display("FAIL rev_cw_steps got=%0d exp=1", step_cnt - s0); end
    checks++; if (bus.pos !== 8'h01) begin failures++; $display("FAIL rev_cw_pos got=%h exp=01", bus.pos); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL rev_cw_dir got=%b exp=1", bus.dir); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL rev_errs got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int  s0;
    int  e0;
    logic exp_step;
    phase(1'b1, 1'b0, 10);
    phase(1'b0, 1'b0, 10);
    rst = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.pos !== 8'h00) begin failures++; $display("FAIL mid_rst_pos got=%h exp=00", bus.pos); end
    checks++; if (bus.dir !== 1'b0) begin failures++; $display("FAIL mid_rst_dir got=%b exp=0", bus.dir); end
    checks++; if (bus.step !== 1'b0) begin failures++; $display("FAIL mid_rst_step got=%b exp=0", bus.step); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", bus.err); end
    rst = 1'b0;
    phase(1'b1, 1'b1, 10);
    s0 = step_cnt;
    e0 = err_cnt;
    phase(1'b1, 1'b0, 10);
    phase(1'b0, 1'b0, 10);
    phase(1'b0, 1'b1, 10);
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_step = (k == 7);
      checks++;
      if (bus.step !== exp_step) begin
        failures++;
        $display("FAIL latency_edge%0d got=%b exp=%b", k, bus.step, exp_step);
      end
    end
    repeat (5) @(negedge clk);
    checks++; if (bus.pos !== 8'h01) begin failures++; $display("FAIL mid_pos got=%h exp=01", bus.pos); end
    checks++; if (step_cnt - s0 !== 1) begin failures++; $display("FAIL mid_steps got=%0d exp=1", step_cnt - s0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL mid_errs got=%0d exp=0", err_cnt - e0); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL mid_dir got=%b exp=1", bus.dir); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    step_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    rst       = 1'b1;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    test_reset();
    test_cw();
    test_ccw();
    test_glitch();
    test_illegal();
    test_reversal();
    test_reset_mid();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL step_err_overlap got=%0d exp=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
